// File: rtl/ps2_rx_controller.sv
// PS/2 keyboard receiver: synchronizes the keyboard lines, frames 11-bit packets,
// folds E0/F0 prefixes into flags and queues scan codes behind valid/ready.
module ps2_rx_controller #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] code,
    output logic       is_ext,
    output logic       is_break,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overflow
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t             state_q, state_d;
    logic               clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
    logic               dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic [2:0]         bitcnt_q, bitcnt_d;
    logic [7:0]         sr_q, sr_d;
    logic               par_ok_q, par_ok_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               ext_q, ext_d, brk_q, brk_d;
    logic               frame_err_q, frame_err_d;
    logic               overflow_q, overflow_d;
    logic [9:0]         mem_q [FIFO_DEPTH];
    logic [9:0]         mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic fe, dat, good, push_req, push, pop, full;

    always_comb begin
        clk_s1_d    = ps2_clk;
        clk_s2_d    = clk_s1_q;
        clk_prev_d  = clk_s2_q;
        dat_s1_d    = ps2_dat;
        dat_s2_d    = dat_s1_q;
        fe          = clk_prev_q & ~clk_s2_q;
        dat         = dat_s2_q;

        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        sr_d        = sr_q;
        par_ok_d    = par_ok_q;
        ext_d       = ext_q;
        brk_d       = brk_q;
        frame_err_d = 1'b0;
        good        = 1'b0;
        push_req    = 1'b0;

        // The watchdog only runs between edges of an open frame.
        if (state_q == S_IDLE || fe) tmo_d = '0;
        else                         tmo_d = tmo_q + TMO_W'(1);

        case (state_q)
            S_IDLE: begin
                if (fe && !dat) begin
                    state_d  = S_DATA;
                    bitcnt_d = 3'd0;
                end
            end
            S_DATA: begin
                if (fe) begin
                    sr_d     = {dat, sr_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                if (fe) begin
                    par_ok_d = (^sr_q) ^ dat;
                    state_d  = S_STOP;
                end
            end
            S_STOP: begin
                if (fe) begin
                    state_d = S_IDLE;
                    if (dat && par_ok_q) good        = 1'b1;
                    else                 frame_err_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered frame_err lands exactly TIMEOUT_CYCLES after the last edge.
        if (state_q != S_IDLE && !fe && tmo_q == TMO_W'(TIMEOUT_CYCLES - 2)) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
        end

        if (good) begin
            if (sr_q == 8'hE0)      ext_d = 1'b1;
            else if (sr_q == 8'hF0) brk_d = 1'b1;
            else begin
                push_req = 1'b1;
                ext_d    = 1'b0;
                brk_d    = 1'b0;
            end
        end
        if (frame_err_d) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end

        pop        = valid & ready;
        full       = (cnt_q == CNT_W'(FIFO_DEPTH));
        push       = push_req & (~full | pop);
        overflow_d = overflow_q | (push_req & full & ~pop);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = {ext_q, brk_q, sr_q};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // NOTE: the queue storage is reset too, so the head outputs read 0 after reset
    // instead of X; at this depth the extra reset fan-out is negligible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            clk_prev_q  <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            bitcnt_q    <= '0;
            sr_q        <= '0;
            par_ok_q    <= 1'b0;
            tmo_q       <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            clk_s1_q    <= clk_s1_d;
            clk_s2_q    <= clk_s2_d;
            clk_prev_q  <= clk_prev_d;
            dat_s1_q    <= dat_s1_d;
            dat_s2_q    <= dat_s2_d;
            bitcnt_q    <= bitcnt_d;
            sr_q        <= sr_d;
            par_ok_q    <= par_ok_d;
            tmo_q       <= tmo_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            mem_q       <= mem_d;
        end
    end

    assign valid                   = (cnt_q != '0);
    assign {is_ext, is_break, code} = mem_q[rd_ptr_q];
    assign frame_err               = frame_err_q;
    assign overflow                = overflow_q;

endmodule

// File: tb/tb_ps2_rx_controller.sv
// Directed bench for ps2_rx_controller: drives PS/2 frames at 40 clk per bit and
// checks delivered codes, prefix flags, error pulses, overflow and reset behaviour.
module tb_ps2_rx_controller;

    logic       clk = 1'b0;
    logic       reset, ps2_clk, ps2_dat, ready;
    logic [7:0] code;
    logic       is_ext, is_break, valid, frame_err, overflow;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         last_fall = 0;
    int         err_cnt  = 0;
    int         err_cyc  = 0;
    logic [9:0] got [$];

    ps2_rx_controller #(.TIMEOUT_CYCLES(200), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .code      (code),
        .is_ext    (is_ext),
        .is_break  (is_break),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every accepted beat as {is_ext, is_break, code} and every error cycle.
    always @(negedge clk) begin
        if (valid && ready) got.push_back({is_ext, is_break, code});
        if (frame_err) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = bits[i];
            repeat (20) @(posedge clk);
            #1 ps2_clk = 1'b0;
            last_fall = cyc;
            repeat (20) @(posedge clk);
            #1 ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        send_bits({stop, par, b, 1'b0}, 11);
        repeat (20) @(posedge clk);
    endtask

    task automatic clear_log();
        @(posedge clk);
        #1;
        got.delete();
        err_cnt = 0;
    endtask

    initial begin
        reset   = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        ready   = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_valid",     32'(valid),     32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_overflow",  32'(overflow),  32'd0);
        check("reset_head",      32'({is_ext, is_break, code}), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        ready = 1'b1;
        repeat (10) @(posedge clk);

        // Single plain code
        clear_log();
        send_frame(8'h1C, 1'b0, 1'b1);
        check("single_beats", 32'(got.size()), 32'd1);
        check("single_entry", 32'(got[0]),     32'h01C);
        check("single_err",   32'(err_cnt),    32'd0);

        // Break prefix
        clear_log();
        send_frame(8'hF0, 1'b1, 1'b1);
        check("brk_prefix_no_beat", 32'(got.size()), 32'd0);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("brk_beats", 32'(got.size()), 32'd1);
        check("brk_entry", 32'(got[0]),     32'h11C);
        check("brk_err",   32'(err_cnt),    32'd0);

        // Extended break, then a plain code with flags cleared
        clear_log();
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("extbrk_beats",  32'(got.size()), 32'd2);
        check("extbrk_entry",  32'(got[0]),     32'h375);
        check("extbrk_plain",  32'(got[1]),     32'h01C);

        // Parity error, then recovery
        clear_log();
        send_frame(8'h1C, 1'b1, 1'b1);
        check("parerr_pulse_cycles", 32'(err_cnt),    32'd1);
        check("parerr_no_beat",      32'(got.size()), 32'd0);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("parerr_recover_beats", 32'(got.size()), 32'd1);
        check("parerr_recover_entry", 32'(got[0]),     32'h01C);

        // Stop bit low
        clear_log();
        send_frame(8'h1C, 1'b0, 1'b0);
        check("stoperr_pulse_cycles", 32'(err_cnt),    32'd1);
        check("stoperr_no_beat",      32'(got.size()), 32'd0);

        // An error between prefix and code clears the prefix flag
        clear_log();
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("errclr_beats", 32'(got.size()), 32'd1);
        check("errclr_entry", 32'(got[0]),     32'h01C);

        // Timeout: start + 4 data bits, then the clock line stays high.
        // fe follows the driven fall by ~2-3 clk; frame_err is TIMEOUT_CYCLES after fe.
        clear_log();
        send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 5);
        repeat (260) @(posedge clk);
        check("tmo_pulse_cycles", 32'(err_cnt), 32'd1);
        check("tmo_latency_window",
              32'((err_cyc - last_fall) >= 201 && (err_cyc - last_fall) <= 204), 32'd1);
        check("tmo_no_beat", 32'(got.size()), 32'd0);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("tmo_recover_beats", 32'(got.size()), 32'd1);
        check("tmo_recover_entry", 32'(got[0]),     32'h01C);
        check("tmo_recover_err",   32'(err_cnt),    32'd1);

        // Overflow: fifth code dropped while ready is low
        @(posedge clk);
        #1 ready = 1'b0;
        clear_log();
        check("ovf_before", 32'(overflow), 32'd0);
        send_frame(8'h16, 1'b0, 1'b1);
        send_frame(8'h1E, 1'b1, 1'b1);
        send_frame(8'h26, 1'b0, 1'b1);
        send_frame(8'h25, 1'b0, 1'b1);
        @(negedge clk);
        check("ovf_not_yet", 32'(overflow), 32'd0);
        send_frame(8'h2E, 1'b1, 1'b1);
        @(negedge clk);
        check("ovf_set",   32'(overflow), 32'd1);
        check("ovf_valid", 32'(valid),    32'd1);
        check("ovf_head",  32'({is_ext, is_break, code}), 32'h016);
        @(posedge clk);
        #1 ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("drain_beats", 32'(got.size()), 32'd4);
        check("drain_0",     32'(got[0]),     32'h016);
        check("drain_1",     32'(got[1]),     32'h01E);
        check("drain_2",     32'(got[2]),     32'h026);
        check("drain_3",     32'(got[3]),     32'h025);
        check("drain_empty", 32'(valid),      32'd0);
        check("ovf_sticky",  32'(overflow),   32'd1);

        // Reset in the middle of a frame
        send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 4);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst_valid",     32'(valid),     32'd0);
        check("midrst_overflow",  32'(overflow),  32'd0);
        check("midrst_frame_err", 32'(frame_err), 32'd0);
        check("midrst_head",      32'({is_ext, is_break, code}), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(posedge clk);
        clear_log();
        send_frame(8'h1C, 1'b0, 1'b1);
        check("postrst_beats", 32'(got.size()), 32'd1);
        check("postrst_entry", 32'(got[0]),     32'h01C);
        check("postrst_err",   32'(err_cnt),    32'd0);
        check("postrst_ovf",   32'(overflow),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
